// File: rtl/counter.sv
// Parameterised up/down counter with active-low parallel load, count enable and
// terminal-value flags. Define COUNTER_SVA_EN to compile in the concurrent assertions.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Next-value select: load beats count, count beats hold; wrap is natural modulo.
    always_comb begin
        w_next = r_count;
        if (!load_n) begin
            w_next = data_load;
        end else if (ce) begin
            if (up_down) begin
                w_next = r_count + ONE;
            end else begin
                w_next = r_count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // Flags decode the register directly so they track count_out in the same cycle.
    assign count_out = r_count;
    assign max_count = (r_count == ALL_ONES);
    assign zero      = (r_count == '0);

`ifdef COUNTER_SVA_EN
    // Step checks only apply when the previous edge was itself out of reset.
    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && !$past(load_n)) |-> (count_out == $past(data_load)))
        else $error("counter: load mismatch");

    a_up: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(load_n) && $past(ce) && $past(up_down))
        |-> (count_out == WIDTH'($past(count_out) + ONE)))
        else $error("counter: up step mismatch");

    a_down: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(load_n) && $past(ce) && !$past(up_down))
        |-> (count_out == WIDTH'($past(count_out) - ONE)))
        else $error("counter: down step mismatch");

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(load_n) && !$past(ce))
        |-> (count_out == $past(count_out)))
        else $error("counter: hold mismatch");

    a_flags: assert property (@(posedge clk) disable iff (!rst_n)
        (max_count == (&count_out)) && (zero == ~(|count_out)))
        else $error("counter: flag decode mismatch");

    a_rst: assert property (@(posedge clk)
        !rst_n |-> (count_out == '0))
        else $error("counter: nonzero while in reset");
`endif

endmodule

// File: tb/tb_counter.sv
// Directed and random self-checking bench for counter (WIDTH = 4).
module tb_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             load_n;
    logic             up_down;
    logic             ce;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;

    int tests_run;
    int tests_failed;

    counter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare count and both flags against a hand-supplied expected count.
    task automatic chk(input string tag, input logic [WIDTH-1:0] exp_cnt);
        logic exp_max;
        logic exp_zero;
        exp_max  = (exp_cnt == 4'hF);
        exp_zero = (exp_cnt == 4'h0);
        tests_run++;
        assert (count_out === exp_cnt) else begin
            tests_failed++;
            $error("FAIL %s count: got %h expected %h", tag, count_out, exp_cnt);
        end
        tests_run++;
        assert (max_count === exp_max) else begin
            tests_failed++;
            $error("FAIL %s max_count: got %b expected %b", tag, max_count, exp_max);
        end
        tests_run++;
        assert (zero === exp_zero) else begin
            tests_failed++;
            $error("FAIL %s zero: got %b expected %b", tag, zero, exp_zero);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] model;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        load_n    = 1'b1;
        up_down   = 1'b1;
        ce        = 1'b0;
        data_load = 4'h0;

        // Reset
        #2;
        chk("reset_async", 4'h0);
        tick();
        chk("reset_held", 4'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("release_hold", 4'h0);

        // Load priority over count
        load_n = 1'b0; data_load = 4'hA; ce = 1'b1; up_down = 1'b1;
        tick();
        chk("load_priority", 4'hA);

        // Up wrap
        data_load = 4'hE;
        tick();
        chk("load_E", 4'hE);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1;
        tick();
        chk("up_to_F", 4'hF);
        tick();
        chk("up_wrap_0", 4'h0);

        // Down wrap from 1
        load_n = 1'b0; data_load = 4'h1;
        tick();
        chk("load_1", 4'h1);
        load_n = 1'b1; up_down = 1'b0;
        tick();
        chk("down_to_0", 4'h0);
        tick();
        chk("down_wrap_F", 4'hF);

        // Hold across 5 cycles with toggling direction
        load_n = 1'b0; data_load = 4'h5;
        tick();
        load_n = 1'b1; ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up_down = i[0];
            tick();
            chk("hold", 4'h5);
        end

        // Async reset mid-count
        load_n = 1'b0; data_load = 4'h7;
        tick();
        chk("load_7", 4'h7);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_mid", 4'h0);
        tick();
        chk("async_held", 4'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_release_up", 4'h1);

        // Random cycles against a reference model
        model = 4'h1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            load_n    = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            ce        = 1'($urandom_range(0, 1));
            up_down   = 1'($urandom_range(0, 1));
            data_load = 4'($urandom_range(0, 15));
            if (!load_n)      model = data_load;
            else if (ce)      model = up_down ? 4'(model + 4'h1) : 4'(model - 4'h1);
            tick();
            chk("random", model);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog keeps the run bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
